tx_block: RTL and testbench

TX_BLOCK -- requirements
Module: tx_block

---
 rtl/tx_block.sv | 145 ++++++++++++++
 tb/tb_tx_block.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_block.sv
// rtl/tx_block.sv - 8N1 serial transmitter with single-byte holding buffer
module tx_block #(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       load_data,
  input  logic       clear_error,
  output logic       serial_out,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       load_error
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] LAST_CNT = 8'(BIT_PERIOD - 1);

  state_t     state, state_n;
  logic [7:0] buf_data;
  logic       buf_full;
  logic [7:0] shift_reg, shift_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic       serial_n;
  logic       done_n;
  logic       take_buf;
  logic       bit_end;

  assign bit_end  = (cnt == LAST_CNT);
  assign tx_ready = ~buf_full;
  assign tx_busy  = (state != IDLE);

  // State register plus the registered datapath that follows it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= 8'h00;
      cnt        <= 8'h00;
      bit_idx    <= 3'd0;
      serial_out <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      shift_reg  <= shift_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      serial_out <= serial_n;
      tx_done    <= done_n;
    end
  end

  // Next-state and next-output logic; a bit boundary is reached when cnt hits BIT_PERIOD-1
  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    cnt_n     = cnt + 8'd1;
    bit_idx_n = bit_idx;
    serial_n  = serial_out;
    done_n    = 1'b0;
    take_buf  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n    = 8'h00;
        serial_n = 1'b1;
        if (buf_full) begin
          state_n  = START;
          take_buf = 1'b1;
          shift_n  = buf_data;
          serial_n = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n     = 8'h00;
          state_n   = DATA;
          bit_idx_n = 3'd0;
          serial_n  = shift_reg[0];
          shift_n   = {1'b0, shift_reg[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = 8'h00;
          if (bit_idx == 3'd7) begin
            state_n  = STOP;
            serial_n = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            serial_n  = shift_reg[0];
            shift_n   = {1'b0, shift_reg[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n  = 8'h00;
          done_n = 1'b1;
          // A waiting byte starts immediately so frames run back-to-back
          if (buf_full) begin
            state_n  = START;
            take_buf = 1'b1;
            shift_n  = buf_data;
            serial_n = 1'b0;
          end else begin
            state_n  = IDLE;
            serial_n = 1'b1;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        cnt_n    = 8'h00;
        serial_n = 1'b1;
      end
    endcase
  end

  // Holding buffer: accept only when empty; emptied when the FSM takes the byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data <= 8'h00;
      buf_full <= 1'b0;
    end else if (load_data && !buf_full) begin
      buf_data <= tx_data;
      buf_full <= 1'b1;
    end else if (take_buf) begin
      buf_full <= 1'b0;
    end
  end

  // Sticky overrun flag; a new overrun wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_error <= 1'b0;
    end else if (load_data && buf_full) begin
      load_error <= 1'b1;
    end else if (clear_error) begin
      load_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_block.sv
// tb/tb_tx_block.sv - scoreboard bench for tx_block at BIT_PERIOD 10 and 2
module tb_tx_block;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data, tx_data2;
  logic       load_data, load_data2;
  logic       clear_error;
  logic       so0, rdy0, busy0, done0, err0;
  logic       so1, rdy1, busy1, done1, err1;

  exp_t q0[$];
  exp_t q1[$];

  int   n_pass;
  int   n_total;

  logic in_frame [2];
  logic done_due [2];
  logic bad      [2];
  int   cnt      [2];
  int   idle     [2];
  int   bp_of    [2];
  exp_t cur      [2];

  tx_block #(.BIT_PERIOD(10)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .load_data(load_data),
    .clear_error(clear_error), .serial_out(so0), .tx_ready(rdy0),
    .tx_busy(busy0), .tx_done(done0), .load_error(err0)
  );

  tx_block #(.BIT_PERIOD(2)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .load_data(load_data2),
    .clear_error(1'b0), .serial_out(so1), .tx_ready(rdy1),
    .tx_busy(busy1), .tx_done(done1), .load_error(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k, input int bp);
    int b;
    b = k / bp;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic mon_step(input int i, input logic r, input logic line, input logic done);
    if (r) begin
      in_frame[i] = 1'b0;
      done_due[i] = 1'b0;
      idle[i]     = 0;
      return;
    end
    if (done_due[i]) begin
      check($sformatf("tx_done_pulse%0d", i), {31'd0, done}, 32'd1);
      done_due[i] = 1'b0;
    end else if (done !== 1'b0) begin
      n_total++;
      $display("FAIL spurious_tx_done%0d: got %b expected 0", i, done);
    end
    if (in_frame[i]) begin
      if (line !== exp_bit(cur[i].data, cnt[i], bp_of[i])) bad[i] = 1'b1;
      cnt[i]++;
    end else if (line === 1'b0) begin
      bad[i] = 1'b0;
      if (i == 0 && q0.size() > 0) cur[i] = q0.pop_front();
      else if (i == 1 && q1.size() > 0) cur[i] = q1.pop_front();
      else begin
        n_total++;
        $display("FAIL unexpected_frame%0d: got frame expected none", i);
        cur[i].data = 8'h00;
        cur[i].gap  = -1;
        bad[i]      = 1'b1;
      end
      if (cur[i].gap >= 0)
        check($sformatf("idle_gap%0d_%02h", i, cur[i].data), idle[i], cur[i].gap);
      in_frame[i] = 1'b1;
      cnt[i]      = 1;
    end else begin
      idle[i]++;
    end
    if (in_frame[i] && cnt[i] == 10 * bp_of[i]) begin
      check($sformatf("frame_bits%0d_%02h", i, cur[i].data), {31'd0, bad[i]}, 32'd0);
      in_frame[i] = 1'b0;
      done_due[i] = 1'b1;
      idle[i]     = 0;
    end
  endtask

  // Monitor: samples both serial lines mid-cycle and scores them against the queues
  always @(negedge clk) begin
    mon_step(0, rst, so0, done0);
    mon_step(1, rst, so1, done1);
  end

  task automatic push0(input logic [7:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = gap;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [7:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = gap;
    q1.push_back(e);
  endtask

  task automatic load_byte(input logic [7:0] d);
    @(negedge clk);
    tx_data   = d;
    load_data = 1'b1;
    @(negedge clk);
    load_data = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (rdy0 !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rdy0 !== 1'b1) begin
      n_total++;
      $display("FAIL %s: tx_ready timeout got %b expected 1", name, rdy0);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy0 === 1'b0 && rdy0 === 1'b1) && n < 500);
    if (busy0 !== 1'b0) begin
      n_total++;
      $display("FAIL %s: idle timeout got busy %b expected 0", name, busy0);
    end
    @(negedge clk);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    for (int i = 0; i < 2; i++) begin
      in_frame[i] = 1'b0;
      done_due[i] = 1'b0;
      bad[i]      = 1'b0;
      cnt[i]      = 0;
      idle[i]     = 0;
    end
    bp_of[0] = 10;
    bp_of[1] = 2;
    rst = 1'b1;
    tx_data = 8'h00;
    tx_data2 = 8'h00;
    load_data = 1'b0;
    load_data2 = 1'b0;
    clear_error = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_serial_out", {31'd0, so0}, 32'd1);
    check("reset_tx_ready", {31'd0, rdy0}, 32'd1);
    check("reset_tx_busy", {31'd0, busy0}, 32'd0);
    check("reset_tx_done", {31'd0, done0}, 32'd0);
    check("reset_load_error", {31'd0, err0}, 32'd0);
    check("reset_serial_out_bp2", {31'd0, so1}, 32'd1);

    // 0xA5 offered together with reset release: taken on the first edge
    push0(8'hA5, -1);
    rst       = 1'b0;
    tx_data   = 8'hA5;
    load_data = 1'b1;
    @(negedge clk);
    load_data = 1'b0;
    check("first_edge_accept_ready", {31'd0, rdy0}, 32'd0);
    check("busy_before_start", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    check("start_bit_line", {31'd0, so0}, 32'd0);
    check("ready_after_start", {31'd0, rdy0}, 32'd1);
    check("busy_after_start", {31'd0, busy0}, 32'd1);
    wait_idle("frame_a5");

    // Back-to-back: 0xC3 queued during 0x3C, no idle cycle between frames
    push0(8'h3C, -1);
    load_byte(8'h3C);
    wait_ready("ready_3c");
    push0(8'hC3, 0);
    load_byte(8'hC3);
    wait_idle("frames_3c_c3");

    // Overrun: 0x33 rejected while the buffer holds 0x22
    push0(8'h11, -1);
    load_byte(8'h11);
    wait_ready("ready_11");
    push0(8'h22, 0);
    load_byte(8'h22);
    check("ready_low_buffer_full", {31'd0, rdy0}, 32'd0);
    check("no_error_yet", {31'd0, err0}, 32'd0);
    load_byte(8'h33);
    check("overrun_sets_error", {31'd0, err0}, 32'd1);
    @(negedge clk);
    check("error_sticky", {31'd0, err0}, 32'd1);
    tx_data     = 8'h44;
    load_data   = 1'b1;
    clear_error = 1'b1;
    @(negedge clk);
    load_data   = 1'b0;
    clear_error = 1'b0;
    check("set_wins_over_clear", {31'd0, err0}, 32'd1);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    check("clear_error", {31'd0, err0}, 32'd0);
    wait_idle("frames_11_22");

    // 0x81 accepted exactly at the stop-end edge of 0x5A: one idle cycle
    push0(8'h5A, -1);
    load_byte(8'h5A);
    repeat (99) @(negedge clk);
    push0(8'h81, 1);
    load_byte(8'h81);
    check("stop_end_done", {31'd0, done0}, 32'd1);
    check("stop_end_accept", {31'd0, rdy0}, 32'd0);
    check("stop_end_idle_line", {31'd0, so0}, 32'd1);
    wait_idle("frame_81");

    // Reset 45 cycles into a 0xFF frame aborts it asynchronously
    push0(8'hFF, -1);
    load_byte(8'hFF);
    repeat (45) @(negedge clk);
    check("busy_mid_ff", {31'd0, busy0}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy0}, 32'd0);
    check("async_rst_line", {31'd0, so0}, 32'd1);
    check("async_rst_ready", {31'd0, rdy0}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    push0(8'h00, -1);
    load_byte(8'h00);
    wait_idle("frame_00");

    // BIT_PERIOD 2 instance: 0x55 then back-to-back 0xAA
    push1(8'h55, -1);
    @(negedge clk);
    tx_data2   = 8'h55;
    load_data2 = 1'b1;
    @(negedge clk);
    load_data2 = 1'b0;
    @(negedge clk);
    check("bp2_ready_after_start", {31'd0, rdy1}, 32'd1);
    push1(8'hAA, 0);
    tx_data2   = 8'hAA;
    load_data2 = 1'b1;
    @(negedge clk);
    load_data2 = 1'b0;
    repeat (60) @(negedge clk);
    check("bp2_idle", {31'd0, busy1}, 32'd0);

    check("queue0_drained", q0.size(), 32'd0);
    check("queue1_drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
